dna_loader: RTL and testbench

DNA_LOADER -- requirements
Module: dna_loader

---
 rtl/dna_loader.sv | 111 +++++++++++
 tb/tb_dna_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dna_loader.sv
// Streams ASCII nucleotides into a 2-bit-per-entry memory starting at a latched base address.
// A load ends in DONE on the last character, or in ERR on an invalid character or overflow.
module dna_loader #(
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset_N,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] max_length,
   input  logic              in_valid,
   input  logic [7:0]        in_char,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_data,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] dna_length,
   output logic [1:0]        debug_state
);

   // Input handshake: a character transfers on a rising edge where in_valid and in_ready are both 1.
   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   localparam logic [ADDR_W-1:0] ONE = 1;

   state_t            state, state_n;
   logic [ADDR_W-1:0] base_q, base_n;
   logic [ADDR_W-1:0] max_q, max_n;
   logic [ADDR_W-1:0] count_q, count_n;
   logic              we_n;
   logic [ADDR_W-1:0] addr_n;
   logic [1:0]        data_n;
   logic              char_ok;
   logic [1:0]        char_code;

   always_comb begin
      char_ok   = 1'b1;
      char_code = 2'b00;
      case (in_char)
         8'h41:   char_code = 2'b00;
         8'h43:   char_code = 2'b01;
         8'h47:   char_code = 2'b10;
         8'h54:   char_code = 2'b11;
         default: char_ok   = 1'b0;
      endcase
   end

   always_comb begin
      state_n = state;
      base_n  = base_q;
      max_n   = max_q;
      count_n = count_q;
      we_n    = 1'b0;
      addr_n  = mem_addr;
      data_n  = mem_data;
      case (state)
         LOAD: begin
            if (in_valid) begin
               // Invalid characters take precedence: either fault aborts without a write.
               if (!char_ok || count_q == max_q) begin
                  state_n = ERR;
               end else begin
                  we_n    = 1'b1;
                  addr_n  = base_q + count_q;
                  data_n  = char_code;
                  count_n = count_q + ONE;
                  if (in_last) state_n = DONE;
               end
            end
         end
         default: begin
            if (start) begin
               base_n  = base_addr;
               max_n   = max_length;
               count_n = '0;
               state_n = LOAD;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state    <= IDLE;
         base_q   <= '0;
         max_q    <= '0;
         count_q  <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= 2'b00;
      end else begin
         state    <= state_n;
         base_q   <= base_n;
         max_q    <= max_n;
         count_q  <= count_n;
         mem_we   <= we_n;
         mem_addr <= addr_n;
         mem_data <= data_n;
      end
   end

   assign in_ready    = (state == LOAD);
   assign done        = (state == DONE);
   assign error       = (state == ERR);
   assign dna_length  = count_q;
   assign debug_state = state;

endmodule

// File: tb/tb_dna_loader.sv
// Scoreboard bench for dna_loader: a behavioural model predicts writes and status,
// a negedge monitor checks every memory write for address, data and cycle.
module tb_dna_loader;
   localparam int ADDR_W = 16;
   localparam int EW = 32 + ADDR_W + 2;

   logic              clock = 1'b0;
   logic              reset_N = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] max_length = '0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_char = 8'h00;
   logic              in_last = 1'b0;
   logic              in_ready, mem_we, done, error;
   logic [ADDR_W-1:0] mem_addr, dna_length;
   logic [1:0]        mem_data, debug_state;

   dna_loader #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset_N(reset_N), .start(start), .base_addr(base_addr),
      .max_length(max_length), .in_valid(in_valid), .in_char(in_char), .in_last(in_last),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .done(done), .error(error), .dna_length(dna_length), .debug_state(debug_state)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];

   // Behavioural model of the load.
   bit m_load = 0, m_done = 0, m_err = 0;
   int m_base = 0, m_max = 0, m_count = 0;
   string nuc = "ACGT";

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int code_of(input logic [7:0] c);
      for (int i = 0; i < 4; i++) if (c == nuc[i]) return i;
      return -1;
   endfunction

   task automatic check_status(input string tag);
      check({tag, "_done"}, done, m_done);
      check({tag, "_error"}, error, m_err);
      check({tag, "_ready"}, in_ready, m_load);
      check({tag, "_len"}, dna_length, m_count);
   endtask

   task automatic do_start(input int base, input int maxl);
      base_addr = base[ADDR_W-1:0];
      max_length = maxl[ADDR_W-1:0];
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      if (!m_load) begin
         m_base = base; m_max = maxl; m_count = 0;
         m_load = 1; m_done = 0; m_err = 0;
      end
   endtask

   task automatic send(input logic [7:0] c, input bit last, input int gap);
      int code;
      repeat (gap) begin @(posedge clock); #1; end
      check("ready_pre", in_ready, m_load);
      in_valid = 1'b1; in_char = c; in_last = last;
      @(posedge clock); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (m_load) begin
         code = code_of(c);
         if (code < 0 || m_count >= m_max) begin
            m_load = 0; m_err = 1;
         end else begin
            exp_q.push_back({cyc, ADDR_W'((m_base + m_count) % (1 << ADDR_W)), code[1:0]});
            m_count++;
            if (last) begin m_load = 0; m_done = 1; end
         end
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1, gap);
      @(posedge clock); #1;
   endtask

   // Monitor: every write must match the queue head, including its cycle.
   always @(negedge clock) begin
      if (done && error) check("done_and_error", 1, 0);
      if (mem_we) begin
         if (exp_q.size() == 0) check("unexpected_write", mem_addr, 'h7fffffff);
         else check("write", {cyc, mem_addr, mem_data}, exp_q.pop_front());
      end else if (exp_q.size() != 0 && exp_q[0][EW-1 -: 32] <= cyc) begin
         check("missing_write", 0, exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] c;
      int n, maxl;
      repeat (3) @(posedge clock);
      #1;
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      check_status("rst");
      reset_N = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      check_status("idle_wait");

      do_start('h0100, 8);
      check_status("gatc_start");
      send_str("GATC", 0);
      check_status("gatc_end");
      check("gatc_len_const", dna_length, 4);
      check("gatc_done_const", done, 1);

      do_start('h0200, 8);
      check("restart_len0", dna_length, 0);
      send_str("ACX", 0);
      check_status("invalid");
      check("invalid_len_const", dna_length, 2);

      do_start('h0300, 2);
      send_str("AAA", 0);
      check_status("overflow");
      check("overflow_err_const", error, 1);

      do_start('h0400, 0);
      send_str("A", 0);
      check_status("max0");

      do_start('hFFFF, 4);
      send_str("TG", 3);
      check_status("wrap");

      do_start('h0500, 8);
      send("C", 0, 0);
      do_start('h0600, 1);
      check_status("start_in_load");
      send_str("GA", 1);
      check_status("start_in_load_end");

      do_start('h0700, 8);
      send("T", 0, 0);
      #1 reset_N = 1'b0;
      exp_q.delete();
      m_load = 0; m_done = 0; m_err = 0; m_count = 0;
      #1;
      check("midrst_we", mem_we, 0);
      check("midrst_addr", mem_addr, 0);
      check("midrst_data", mem_data, 0);
      check_status("midrst");
      in_valid = 1'b1; in_char = "A";
      repeat (2) @(posedge clock);
      #1 in_valid = 1'b0;
      reset_N = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
      check_status("post_rst");

      for (int t = 0; t < 40; t++) begin
         maxl = $urandom_range(0, 10);
         n = $urandom_range(1, 12);
         do_start($urandom_range(0, 65535), maxl);
         for (int i = 0; i < n && m_load; i++) begin
            if ($urandom_range(0, 15) == 0) begin
               do c = 8'($urandom_range(0, 255)); while (code_of(c) >= 0);
            end else c = nuc[$urandom_range(0, 3)];
            send(c, i == n - 1, $urandom_range(0, 2));
         end
         @(posedge clock); #1;
         check_status("rand");
      end

      repeat (3) begin @(posedge clock); #1; end
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
